// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the destination-register scoreboard.
// Optional build macro: SCOREBOARD_WB_BYPASS_EN. When it is defined, a
// WB-only match selects the retired-value hold register (FWD_HOLD).
package mips_pipe_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = $clog2(NUM_REGS);

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;
  localparam logic [1:0] FWD_HOLD = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             is_load;
  } slot_t;

  localparam slot_t EMPTY_SLOT = '0;

  // Youngest producer wins. A WB-only hit uses the hold register only when
  // the register file cannot write before read.
  function automatic logic [1:0] fwd_select(input logic ex_hit,
                                            input logic mem_hit,
                                            input logic wb_hit);
    logic [1:0] wb_code;
    logic [1:0] sel;
`ifdef SCOREBOARD_WB_BYPASS_EN
    wb_code = FWD_HOLD;
`else
    wb_code = FWD_RF;
`endif
    if (ex_hit)       sel = FWD_MEM;
    else if (mem_hit) sel = FWD_WB;
    else if (wb_hit)  sel = wb_code;
    else              sel = FWD_RF;
    return sel;
  endfunction

endpackage

// File: rtl/scoreboard_slot_cmp.sv
// Match comparator for one in-flight slot against one ID source register.
// Register 0 is hardwired zero, so it never produces a match.
module scoreboard_slot_cmp
  import mips_pipe_pkg::*;
(
  input  logic             valid,
  input  logic [REG_W-1:0] dst,
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  output logic             match
);

  assign match = valid && (dst != '0) && (dst == src) && use_src;

endmodule

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: tracks EX/MEM/WB destinations, produces
// registered forwarding selects for EX and a combinational load-use stall.
// Optional build macro: SCOREBOARD_WB_BYPASS_EN (WB-only match -> 2'b11).
module dest_reg_scoreboard
  import mips_pipe_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [REG_W-1:0] IdRs,
  input  logic [REG_W-1:0] IdRt,
  input  logic             IdUseRs,
  input  logic             IdUseRt,
  input  logic [REG_W-1:0] IdDst,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic             Flush,
  output logic             Stall,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [REG_W-1:0] ExDst
);

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  slot_t      slots [3];
  logic       hit_a [3];
  logic       hit_b [3];
  logic       bubble;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  for (genvar i = 0; i < 3; i++) begin : g_cmp
    scoreboard_slot_cmp u_cmp_a (
      .valid   (slots[i].valid),
      .dst     (slots[i].dst),
      .src     (IdRs),
      .use_src (IdUseRs),
      .match   (hit_a[i])
    );
    scoreboard_slot_cmp u_cmp_b (
      .valid   (slots[i].valid),
      .dst     (slots[i].dst),
      .src     (IdRt),
      .use_src (IdUseRt),
      .match   (hit_b[i])
    );
  end

  assign Stall  = slots[EX].is_load && (hit_a[EX] || hit_b[EX]);
  assign bubble = Stall || Flush;
  assign ExDst  = slots[EX].dst;

  // Forwarding decision made in ID, to be registered as the instruction enters EX.
  always_comb begin
    fwd_a_next = fwd_select(hit_a[EX], hit_a[MEM], hit_a[WB]);
    fwd_b_next = fwd_select(hit_b[EX], hit_b[MEM], hit_b[WB]);
  end

  // Advance the shadow slots; a stall or flush drops a bubble into EX.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      slots[EX]  <= EMPTY_SLOT;
      slots[MEM] <= EMPTY_SLOT;
      slots[WB]  <= EMPTY_SLOT;
      ForwardA   <= FWD_RF;
      ForwardB   <= FWD_RF;
    end else begin
      slots[WB]  <= slots[MEM];
      slots[MEM] <= slots[EX];
      if (bubble) begin
        slots[EX] <= EMPTY_SLOT;
        ForwardA  <= FWD_RF;
        ForwardB  <= FWD_RF;
      end else begin
        slots[EX] <= '{valid: IdRegWrite, dst: IdDst, is_load: IdMemRead};
        ForwardA  <= fwd_a_next;
        ForwardB  <= fwd_b_next;
      end
    end
  end

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Directed testbench for dest_reg_scoreboard with hand-computed expectations.
module tb_dest_reg_scoreboard;
  import mips_pipe_pkg::*;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic [1:0] WB_EXP = 2'b11;
`else
  localparam logic [1:0] WB_EXP = 2'b00;
`endif

  logic             Clk = 1'b0;
  logic             Rst;
  logic [REG_W-1:0] IdRs, IdRt, IdDst;
  logic             IdUseRs, IdUseRt, IdRegWrite, IdMemRead, Flush;
  logic             Stall;
  logic [1:0]       ForwardA, ForwardB;
  logic [REG_W-1:0] ExDst;

  int vectors     = 0;
  int miscompares = 0;

  // Free-running pipeline clock.
  always #5 Clk = ~Clk;

  dest_reg_scoreboard dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .IdRs       (IdRs),
    .IdRt       (IdRt),
    .IdUseRs    (IdUseRs),
    .IdUseRt    (IdUseRt),
    .IdDst      (IdDst),
    .IdRegWrite (IdRegWrite),
    .IdMemRead  (IdMemRead),
    .Flush      (Flush),
    .Stall      (Stall),
    .ForwardA   (ForwardA),
    .ForwardB   (ForwardB),
    .ExDst      (ExDst)
  );

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt,
                                input logic [4:0] dst, input logic rw,
                                input logic mr, input logic fl);
    IdRs = rs; IdRt = rt; IdUseRs = urs; IdUseRt = urt;
    IdDst = dst; IdRegWrite = rw; IdMemRead = mr; Flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    Rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_output("rst_fwd_a", ForwardA, 2'b00);
    check_output("rst_fwd_b", ForwardB, 2'b00);
    check_output("rst_exdst", ExDst, 5'd0);
    check_output("rst_stall", Stall, 1'b0);
    Rst = 1'b0;

    // Back-to-back ALU dependency.
    apply_stimulus(1, 2, 1, 1, 3, 1, 0, 0);
    tick();
    check_output("b2b_exdst", ExDst, 5'd3);
    apply_stimulus(3, 4, 1, 1, 8, 1, 0, 0);
    check_output("b2b_stall", Stall, 1'b0);
    tick();
    check_output("b2b_fwd_a", ForwardA, 2'b01);
    check_output("b2b_fwd_b", ForwardB, 2'b00);
    drain();

    // Distance-two dependency on Rt.
    apply_stimulus(0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    apply_stimulus(1, 2, 1, 1, 10, 1, 0, 0);
    tick();
    apply_stimulus(6, 5, 1, 1, 11, 1, 0, 0);
    check_output("d2_stall", Stall, 1'b0);
    tick();
    check_output("d2_fwd_b", ForwardB, 2'b10);
    check_output("d2_fwd_a", ForwardA, 2'b00);
    drain();

    // Load-use: one stall cycle, bubble, then forward from WB path.
    apply_stimulus(0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    check_output("lu_exdst_load", ExDst, 5'd7);
    apply_stimulus(7, 0, 1, 0, 12, 1, 0, 0);
    check_output("lu_stall_on", Stall, 1'b1);
    tick();
    check_output("lu_bubble_exdst", ExDst, 5'd0);
    check_output("lu_bubble_fwd_a", ForwardA, 2'b00);
    check_output("lu_stall_off", Stall, 1'b0);
    tick();
    check_output("lu_fwd_a", ForwardA, 2'b10);
    check_output("lu_exdst_cons", ExDst, 5'd12);
    drain();

    // Register zero never matches, even for a load.
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    apply_stimulus(0, 0, 1, 1, 2, 1, 0, 0);
    check_output("r0_stall", Stall, 1'b0);
    tick();
    check_output("r0_fwd_a", ForwardA, 2'b00);
    check_output("r0_fwd_b", ForwardB, 2'b00);
    drain();

    // Flushed producer never forwards.
    apply_stimulus(0, 0, 0, 0, 9, 1, 0, 1);
    tick();
    check_output("fl_exdst", ExDst, 5'd0);
    apply_stimulus(9, 0, 1, 0, 2, 1, 0, 0);
    tick();
    check_output("fl_fwd_a", ForwardA, 2'b00);
    drain();

    // Use bits gate matching.
    apply_stimulus(0, 0, 0, 0, 13, 1, 0, 0);
    tick();
    apply_stimulus(13, 13, 0, 1, 2, 1, 0, 0);
    tick();
    check_output("use_fwd_a", ForwardA, 2'b00);
    check_output("use_fwd_b", ForwardB, 2'b01);
    drain();

    // WB-slot match: hold register only with the bypass build.
    apply_stimulus(0, 0, 0, 0, 6, 1, 0, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    apply_stimulus(6, 0, 1, 0, 2, 1, 0, 0);
    tick();
    check_output("wb_fwd_a", ForwardA, WB_EXP);
    drain();

    // Reset in the middle of a load-use stall.
    apply_stimulus(0, 0, 0, 0, 4, 1, 1, 0);
    tick();
    apply_stimulus(4, 0, 1, 0, 14, 1, 0, 0);
    check_output("mr_stall_pre", Stall, 1'b1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
    check_output("mr_stall", Stall, 1'b0);
    check_output("mr_fwd_a", ForwardA, 2'b00);
    check_output("mr_fwd_b", ForwardB, 2'b00);
    check_output("mr_exdst", ExDst, 5'd0);
    tick();
    check_output("mr_cons_exdst", ExDst, 5'd14);
    check_output("mr_cons_fwd_a", ForwardA, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
